// File: rtl/axis_channel_arbiter_if.sv
// Stream bundle around the channel arbiter: flattened per-channel capture inputs
// and the single merged AXI-Stream output.
interface axis_channel_arbiter_if #(
    parameter int unsigned CHANNELS   = 6,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ID_WIDTH   = 32,
    parameter int unsigned DEST_WIDTH = 32,
    parameter int unsigned USER_WIDTH = 64
);
    logic [CHANNELS-1:0]              in_tvalid;
    logic [CHANNELS-1:0]              in_tready;
    logic [CHANNELS*DATA_WIDTH-1:0]   in_tdata;
    logic [CHANNELS*DATA_WIDTH/8-1:0] in_tkeep;
    logic [CHANNELS-1:0]              in_tlast;
    logic [CHANNELS*ID_WIDTH-1:0]     in_tid;
    logic [CHANNELS*USER_WIDTH-1:0]   in_tuser;

    logic                             stream_tvalid;
    logic                             stream_tready;
    logic [DATA_WIDTH-1:0]            stream_tdata;
    logic [DATA_WIDTH/8-1:0]          stream_tkeep;
    logic [DATA_WIDTH/8-1:0]          stream_tstrb;
    logic                             stream_tlast;
    logic [ID_WIDTH-1:0]              stream_tid;
    logic [DEST_WIDTH-1:0]            stream_tdest;
    logic [USER_WIDTH-1:0]            stream_tuser;

    // Arbiter side: consumes the channel streams, masters the merged stream.
    modport master (
        input  in_tvalid, in_tdata, in_tkeep, in_tlast, in_tid, in_tuser,
        output in_tready,
        output stream_tvalid, stream_tdata, stream_tkeep, stream_tstrb, stream_tlast,
        output stream_tid, stream_tdest, stream_tuser,
        input  stream_tready
    );

    // Environment side: capture sources plus the downstream sink.
    modport slave (
        output in_tvalid, in_tdata, in_tkeep, in_tlast, in_tid, in_tuser,
        input  in_tready,
        input  stream_tvalid, stream_tdata, stream_tkeep, stream_tstrb, stream_tlast,
        input  stream_tid, stream_tdest, stream_tuser,
        output stream_tready
    );
endinterface

// File: rtl/axis_channel_arbiter.sv
// Round-robin, packet-atomic arbiter merging per-channel capture streams onto one
// registered AXI-Stream output; the granted channel index is stamped into tdest.
module axis_channel_arbiter #(
    parameter int unsigned CHANNELS   = 6,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ID_WIDTH   = 32,
    parameter int unsigned DEST_WIDTH = 32,
    parameter int unsigned USER_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CHANNELS-1:0]    channel_enable,
    output logic [CHANNELS-1:0]    grant,
    output logic                   busy,
    axis_channel_arbiter_if.master bus
);
    localparam int unsigned IdxW  = $clog2(CHANNELS);
    localparam int unsigned KeepW = DATA_WIDTH / 8;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       grant_idx_q, grant_idx_d;
    logic [IdxW-1:0]       last_grant_q, last_grant_d;
    logic [CHANNELS-1:0]   req;
    logic [IdxW-1:0]       cand;
    logic [IdxW-1:0]       pick_idx;
    logic                  pick_valid;
    logic                  out_ready;
    logic                  accept;
    logic                  sel_last;

    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [KeepW-1:0]      tkeep_q, tkeep_d;
    logic [ID_WIDTH-1:0]   tid_q, tid_d;
    logic [USER_WIDTH-1:0] tuser_q, tuser_d;
    logic [DEST_WIDTH-1:0] tdest_q, tdest_d;

    assign req = bus.in_tvalid & channel_enable;

    // First requester strictly after the previous winner, wrapping modulo CHANNELS.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned off = 1; off <= CHANNELS; off++) begin
            cand = IdxW'((32'(last_grant_q) + off) % CHANNELS);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign sel_last  = bus.in_tlast[grant_idx_q];
    assign out_ready = !tvalid_q || bus.stream_tready;
    assign accept    = (state_q == StBusy) && bus.in_tvalid[grant_idx_q] && out_ready;

    always_comb begin
        bus.in_tready = '0;
        if (state_q == StBusy) begin
            bus.in_tready[grant_idx_q] = out_ready;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_idx_d  = grant_idx_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d     = StBusy;
                    grant_idx_d = pick_idx;
                end
            end
            StBusy: begin
                if (accept && sel_last) begin
                    state_d      = StIdle;
                    last_grant_d = grant_idx_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tid_d    = tid_q;
        tuser_d  = tuser_q;
        tdest_d  = tdest_q;
        if (accept) begin
            tvalid_d = 1'b1;
            tlast_d  = sel_last;
            tdata_d  = bus.in_tdata[32'(grant_idx_q) * DATA_WIDTH +: DATA_WIDTH];
            tkeep_d  = bus.in_tkeep[32'(grant_idx_q) * KeepW +: KeepW];
            tid_d    = bus.in_tid[32'(grant_idx_q) * ID_WIDTH +: ID_WIDTH];
            tuser_d  = bus.in_tuser[32'(grant_idx_q) * USER_WIDTH +: USER_WIDTH];
            tdest_d  = DEST_WIDTH'(grant_idx_q);
        end else if (bus.stream_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            grant_idx_q  <= '0;
            last_grant_q <= IdxW'(CHANNELS - 1);
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tdata_q      <= '0;
            tkeep_q      <= '0;
            tid_q        <= '0;
            tuser_q      <= '0;
            tdest_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_idx_q  <= grant_idx_d;
            last_grant_q <= last_grant_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            tdata_q      <= tdata_d;
            tkeep_q      <= tkeep_d;
            tid_q        <= tid_d;
            tuser_q      <= tuser_d;
            tdest_q      <= tdest_d;
        end
    end

    assign grant = (state_q == StBusy) ? (CHANNELS'(1) << grant_idx_q) : '0;
    assign busy  = (state_q == StBusy);

    assign bus.stream_tvalid = tvalid_q;
    assign bus.stream_tlast  = tlast_q;
    assign bus.stream_tdata  = tdata_q;
    assign bus.stream_tkeep  = tkeep_q;
    assign bus.stream_tstrb  = tkeep_q;
    assign bus.stream_tid    = tid_q;
    assign bus.stream_tuser  = tuser_q;
    assign bus.stream_tdest  = tdest_q;
endmodule
